mac_pipe: RTL

- Parametrised, two-stage pipelined signed multiply-accumulate engine; next generation of the team's 8-bit MAC.
- Adds configurable widths, framed accumulation with first/last markers, saturating or wrapping arithmetic, a sticky overflow flag, a term counter and a registered result port.
- Sits between the operand streamers and the result/writeback logic in the datapath.

---
 rtl/mac_pkg.sv | 33 +++
 rtl/mac_sat_add.sv | 38 +++
 rtl/mac_pipe.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the pipelined multiply-accumulate engine.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
//
// Contents: default widths, overflow-mode enum, and accumulator limit helpers.
package mac_pkg;

    localparam int IN_W_DEF  = 8;
    localparam int ACC_W_DEF = 26;
    localparam int CNT_W_DEF = 8;

    typedef enum logic {
        OVF_WRAP = 1'b0,
        OVF_SAT  = 1'b1
    } ovf_mode_e;

    // Maps the integer SAT parameter onto the overflow-mode enum.
    function automatic ovf_mode_e ovf_mode(input int sat);
        return (sat != 0) ? OVF_SAT : OVF_WRAP;
    endfunction

    // Largest signed value of a w-bit accumulator; callers truncate to w bits.
    function automatic logic [127:0] acc_max(input int w);
        return (128'd1 << (w - 1)) - 128'd1;
    endfunction

    // Smallest signed value of a w-bit accumulator; the low w bits of the
    // complement of max are exactly 1000...0.
    function automatic logic [127:0] acc_min(input int w);
        return ~acc_max(w);
    endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Signed ACC_W adder with overflow detect and optional clamp to max/min.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of its inputs).
//
// Ports:
//   a, b     signed addends (ACC_W)
//   sum      wrapped or clamped result (ACC_W), depending on SAT
//   ovf_hit  the true sum does not fit in ACC_W signed bits
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int SAT   = 1
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf_hit
);

    localparam ovf_mode_e        MODE  = ovf_mode(SAT);
    localparam logic [ACC_W-1:0] MAX_V = ACC_W'(acc_max(ACC_W));
    localparam logic [ACC_W-1:0] MIN_V = ACC_W'(acc_min(ACC_W));

    logic [ACC_W:0] wide;

    always_comb begin
        wide    = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        // The extra bit is the true sign; disagreement with the ACC_W sign
        // bit means the result left the representable range.
        ovf_hit = wide[ACC_W] ^ wide[ACC_W-1];
        sum     = wide[ACC_W-1:0];
        if ((MODE == OVF_SAT) && ovf_hit) begin
            sum = wide[ACC_W] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/mac_pipe.sv
// Two-stage signed multiply-accumulate with first/last framing, sticky overflow and term count.
// Latency: term captured at edge N+1 is in acc after edge N+2; res and res_vld follow the same edge.
// Backpressure: none; one term per cycle is always accepted.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_vld               operands valid; qualifies in_first / in_last
//   in_first, in_last    frame start / end markers
//   in1, in2             signed operands (IN_W)
//   acc                  running accumulator (ACC_W, signed)
//   res, res_vld         frame result (held) and its one-cycle update pulse
//   ovf                  sticky overflow of the current/last frame
//   cnt                  terms accumulated in the current frame (saturating)
module mac_pipe
    import mac_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int SAT   = 1,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [IN_W-1:0]  in1,
    input  logic [IN_W-1:0]  in2,
    output logic [ACC_W-1:0] acc,
    output logic [ACC_W-1:0] res,
    output logic             res_vld,
    output logic             ovf,
    output logic [CNT_W-1:0] cnt
);

    localparam int PW = 2 * IN_W;

    generate
        if (ACC_W < PW) begin : g_width_check
            $error("mac_pipe: ACC_W must be at least 2*IN_W");
        end
    endgenerate

    // ---------------- stage 1: multiply ----------------
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod_q;
    logic                 p_vld;
    logic                 p_first;
    logic                 p_last;

    // Widening first keeps the product exact at PW bits.
    assign a_ext = PW'($signed(in1));
    assign b_ext = PW'($signed(in2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q  <= '0;
            p_vld   <= 1'b0;
            p_first <= 1'b0;
            p_last  <= 1'b0;
        end else begin
            p_vld   <= in_vld;
            // Markers on an idle beat are dropped here so stage 2 never sees them.
            p_first <= in_vld & in_first;
            p_last  <= in_vld & in_last;
            if (in_vld) begin
                prod_q <= a_ext * b_ext;
            end
        end
    end

    // ---------------- stage 2: accumulate ----------------
    logic signed [ACC_W-1:0] ext;
    logic        [ACC_W-1:0] sum_sat;
    logic                    ovf_hit;
    logic        [ACC_W-1:0] acc_nxt;

    assign ext = ACC_W'(prod_q);

    mac_sat_add #(
        .ACC_W (ACC_W),
        .SAT   (SAT)
    ) u_add (
        .a       (acc),
        .b       (ext),
        .sum     (sum_sat),
        .ovf_hit (ovf_hit)
    );

    // A first term restarts the frame; the product always fits so no clamp.
    always_comb begin
        acc_nxt = sum_sat;
        if (p_first) begin
            acc_nxt = ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            res     <= '0;
            res_vld <= 1'b0;
            ovf     <= 1'b0;
            cnt     <= '0;
        end else begin
            res_vld <= p_vld & p_last;
            if (p_vld) begin
                acc <= acc_nxt;
                if (p_first) begin
                    ovf <= 1'b0;
                    cnt <= CNT_W'(1);
                end else begin
                    ovf <= ovf | ovf_hit;
                    if (cnt != {CNT_W{1'b1}}) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                if (p_last) begin
                    res <= acc_nxt;
                end
            end
        end
    end

endmodule
